// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bundle.
// Pipeline side (master) drives the ID/EX operand and hazard information plus the
// data-cache status. The controller side (slave) returns PC/IF-ID/ID-EX controls,
// the global Memstall hold, performance counters and the sticky watchdog flag.
//   id_rs1_i, id_rs2_i   : source registers of the instruction in ID
//   idex_memread_i       : instruction in EX is a load
//   idex_rd_i            : destination register of the instruction in EX
//   branch_taken_i       : branch resolved taken in ID
//   dcache_req_i/hit_i   : MEM-stage data-cache access and its hit status
//   mem_ack_i            : refill complete pulse
//   pc_write_o .. mem_stall_o : pipeline controls
//   stall_cnt_o, miss_cnt_o   : saturating performance counters
//   err_timeout_o        : sticky miss watchdog error
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       id_rs1_i;
    logic [4:0]       id_rs2_i;
    logic             idex_memread_i;
    logic [4:0]       idex_rd_i;
    logic             branch_taken_i;
    logic             dcache_req_i;
    logic             dcache_hit_i;
    logic             mem_ack_i;
    logic             pc_write_o;
    logic             ifid_write_o;
    logic             ifid_flush_o;
    logic             idex_bubble_o;
    logic             mem_stall_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] miss_cnt_o;
    logic             err_timeout_o;

    modport master (
        output id_rs1_i, id_rs2_i, idex_memread_i, idex_rd_i, branch_taken_i,
               dcache_req_i, dcache_hit_i, mem_ack_i,
        input  pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, mem_stall_o,
               stall_cnt_o, miss_cnt_o, err_timeout_o
    );

    modport slave (
        input  id_rs1_i, id_rs2_i, idex_memread_i, idex_rd_i, branch_taken_i,
               dcache_req_i, dcache_hit_i, mem_ack_i,
        output pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, mem_stall_o,
               stall_cnt_o, miss_cnt_o, err_timeout_o
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Combines data-cache miss stalls, load-use hazards and ID-stage branch flushes into
// one prioritised control set, runs the cache-miss wait FSM with a watchdog, and keeps
// saturating load-use-bubble and miss counters.
//   clk_i : rising-edge clock
//   rst_i : synchronous active-high reset
//   hz    : hazard controller bundle (slave side), see pipeline_hazard_ctrl_if
module pipeline_hazard_ctrl #(
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    pipeline_hazard_ctrl_if.slave hz
);
    localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MISS_WAIT = 2'd1,
        RESUME    = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WD_W-1:0]  wdog_q, wdog_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

    logic miss;
    logic load_use;
    logic mem_stall;
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            wdog_q      <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            wdog_q      <= wdog_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    // Miss detection and stall are combinational so the pipeline freezes in the
    // very cycle the missing access is presented.
    always_comb begin
        miss      = (state_q == IDLE) && hz.dcache_req_i && !hz.dcache_hit_i;
        mem_stall = !rst_i && (miss || (state_q != IDLE));
        load_use  = hz.idex_memread_i && (hz.idex_rd_i != 5'd0) &&
                    ((hz.idex_rd_i == hz.id_rs1_i) || (hz.idex_rd_i == hz.id_rs2_i));
    end

    always_comb begin
        state_d    = state_q;
        wdog_d     = wdog_q;
        err_d      = err_q;
        miss_cnt_d = miss_cnt_q;
        case (state_q)
            IDLE: begin
                wdog_d = '0;
                if (miss) begin
                    state_d = MISS_WAIT;
                    if (miss_cnt_q != '1) begin
                        miss_cnt_d = miss_cnt_q + CNT_W'(1);
                    end
                end
            end
            MISS_WAIT: begin
                if (hz.mem_ack_i) begin
                    state_d = RESUME;
                    wdog_d  = '0;
                end else if (wdog_q == WD_LAST) begin
                    // Watchdog saturates here; the miss keeps waiting for its ack.
                    err_d = 1'b1;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            RESUME: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Priority: memory stall holds everything, then load-use bubble (which also
    // suppresses a branch flush until the hazard clears), then branch flush.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        stall_cnt_d = stall_cnt_q;
        if (rst_i) begin
            pc_write = 1'b1;
        end else if (mem_stall) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            if (stall_cnt_q != '1) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end else if (hz.branch_taken_i) begin
            ifid_flush = 1'b1;
        end
    end

    assign hz.pc_write_o    = pc_write;
    assign hz.ifid_write_o  = ifid_write;
    assign hz.ifid_flush_o  = ifid_flush;
    assign hz.idex_bubble_o = idex_bubble;
    assign hz.mem_stall_o   = mem_stall;
    assign hz.stall_cnt_o   = stall_cnt_q;
    assign hz.miss_cnt_o    = miss_cnt_q;
    assign hz.err_timeout_o = err_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    logic [4:0] rs1, rs2, rd;
    logic       memread, branch, req, hit, ack;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    // dut_a: wide counters, long watchdog. dut_b: 2-bit counters, 8-cycle watchdog.
    pipeline_hazard_ctrl_if #(.CNT_W(32)) ifa ();
    pipeline_hazard_ctrl_if #(.CNT_W(2))  ifb ();

    assign ifa.id_rs1_i       = rs1;
    assign ifa.id_rs2_i       = rs2;
    assign ifa.idex_memread_i = memread;
    assign ifa.idex_rd_i      = rd;
    assign ifa.branch_taken_i = branch;
    assign ifa.dcache_req_i   = req;
    assign ifa.dcache_hit_i   = hit;
    assign ifa.mem_ack_i      = ack;
    assign ifb.id_rs1_i       = rs1;
    assign ifb.id_rs2_i       = rs2;
    assign ifb.idex_memread_i = memread;
    assign ifb.idex_rd_i      = rd;
    assign ifb.branch_taken_i = branch;
    assign ifb.dcache_req_i   = req;
    assign ifb.dcache_hit_i   = hit;
    assign ifb.mem_ack_i      = ack;

    pipeline_hazard_ctrl #(.CNT_W(32), .TIMEOUT_CYCLES(1024)) dut_a (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .hz    (ifa)
    );

    pipeline_hazard_ctrl #(.CNT_W(2), .TIMEOUT_CYCLES(8)) dut_b (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .hz    (ifb)
    );

    task automatic clear_inputs();
        rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
        memread = 1'b0; branch = 1'b0; req = 1'b0; hit = 1'b0; ack = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        clear_inputs();
        next_cycle();
        next_cycle();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        clear_inputs();
        req = 1'b1; hit = 1'b0; memread = 1'b1; rd = 5'd3; rs1 = 5'd3;
        next_cycle();
        next_cycle();
        @(negedge clk_i);
        total++;
        if (ifa.mem_stall_o !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", ifa.mem_stall_o); end
        total++;
        if ({ifa.pc_write_o, ifa.ifid_write_o, ifa.ifid_flush_o, ifa.idex_bubble_o} !== 4'b1100) begin
            bad++;
            $display("FAIL rst_ctrl got=%b exp=1100",
                     {ifa.pc_write_o, ifa.ifid_write_o, ifa.ifid_flush_o, ifa.idex_bubble_o});
        end
        next_cycle();
        rst_i = 1'b0;
        clear_inputs();
        @(negedge clk_i);
        total++;
        if (ifa.stall_cnt_o !== 32'd0 || ifa.miss_cnt_o !== 32'd0) begin
            bad++;
            $display("FAIL rst_cnt got=%0d/%0d exp=0/0", ifa.stall_cnt_o, ifa.miss_cnt_o);
        end
        total++;
        if (ifa.err_timeout_o !== 1'b0 || ifa.mem_stall_o !== 1'b0) begin
            bad++;
            $display("FAIL rst_idle got err=%b stall=%b exp=0/0", ifa.err_timeout_o, ifa.mem_stall_o);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        memread = 1'b1; rd = 5'd5; rs1 = 5'd7; rs2 = 5'd5;
        @(negedge clk_i);
        total++;
        if ({ifa.pc_write_o, ifa.ifid_write_o, ifa.idex_bubble_o, ifa.ifid_flush_o} !== 4'b0010) begin
            bad++;
            $display("FAIL lu_ctrl got=%b exp=0010",
                     {ifa.pc_write_o, ifa.ifid_write_o, ifa.idex_bubble_o, ifa.ifid_flush_o});
        end
        total++;
        if (ifa.stall_cnt_o !== 32'd0) begin bad++; $display("FAIL lu_cnt_before got=%0d exp=0", ifa.stall_cnt_o); end
        next_cycle();
        memread = 1'b0;
        @(negedge clk_i);
        total++;
        if (ifa.stall_cnt_o !== 32'd1) begin bad++; $display("FAIL lu_cnt_after got=%0d exp=1", ifa.stall_cnt_o); end
        total++;
        if (ifa.pc_write_o !== 1'b1 || ifa.idex_bubble_o !== 1'b0) begin
            bad++;
            $display("FAIL lu_release got pc=%b bub=%b exp=1/0", ifa.pc_write_o, ifa.idex_bubble_o);
        end
        // rs1 match path
        memread = 1'b1; rd = 5'd9; rs1 = 5'd9; rs2 = 5'd1;
        @(negedge clk_i);
        total++;
        if (ifa.idex_bubble_o !== 1'b1) begin bad++; $display("FAIL lu_rs1 got=%b exp=1", ifa.idex_bubble_o); end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_x0_branch();
        do_reset();
        memread = 1'b1; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd4;
        @(negedge clk_i);
        total++;
        if (ifa.pc_write_o !== 1'b1 || ifa.idex_bubble_o !== 1'b0) begin
            bad++;
            $display("FAIL x0_nostall got pc=%b bub=%b exp=1/0", ifa.pc_write_o, ifa.idex_bubble_o);
        end
        next_cycle();
        branch = 1'b1;
        @(negedge clk_i);
        total++;
        if ({ifa.ifid_flush_o, ifa.pc_write_o, ifa.ifid_write_o, ifa.idex_bubble_o} !== 4'b1110) begin
            bad++;
            $display("FAIL br_flush got=%b exp=1110",
                     {ifa.ifid_flush_o, ifa.pc_write_o, ifa.ifid_write_o, ifa.idex_bubble_o});
        end
        next_cycle();
        branch = 1'b0;
        @(negedge clk_i);
        total++;
        if (ifa.ifid_flush_o !== 1'b0) begin bad++; $display("FAIL br_oneshot got=%b exp=0", ifa.ifid_flush_o); end
        total++;
        if (ifa.stall_cnt_o !== 32'd0) begin bad++; $display("FAIL x0_cnt got=%0d exp=0", ifa.stall_cnt_o); end
        clear_inputs();
    endtask

    task automatic test_miss();
        int stall_cycles;
        do_reset();
        stall_cycles = 0;
        req = 1'b1; hit = 1'b0;
        for (int c = 0; c < 12; c++) begin
            ack = (c == 10);
            if (c == 11) hit = 1'b1;
            @(negedge clk_i);
            if (ifa.mem_stall_o === 1'b1 && ifa.pc_write_o === 1'b0 && ifa.ifid_write_o === 1'b0)
                stall_cycles++;
            if (c == 0) begin
                total++;
                if (ifa.miss_cnt_o !== 32'd0) begin bad++; $display("FAIL miss_cnt_early got=%0d exp=0", ifa.miss_cnt_o); end
            end
            next_cycle();
        end
        ack = 1'b0;
        @(negedge clk_i);
        total++;
        if (stall_cycles != 12) begin bad++; $display("FAIL miss_len got=%0d exp=12", stall_cycles); end
        total++;
        if (ifa.mem_stall_o !== 1'b0) begin bad++; $display("FAIL miss_done got=%b exp=0", ifa.mem_stall_o); end
        total++;
        if (ifa.miss_cnt_o !== 32'd1) begin bad++; $display("FAIL miss_cnt got=%0d exp=1", ifa.miss_cnt_o); end
        clear_inputs();
    endtask

    task automatic test_combined();
        do_reset();
        req = 1'b1; hit = 1'b0; memread = 1'b1; rd = 5'd6; rs1 = 5'd6; branch = 1'b1;
        for (int c = 0; c < 3; c++) begin
            ack = (c == 1);
            if (c == 2) hit = 1'b1;
            @(negedge clk_i);
            total++;
            if ({ifa.mem_stall_o, ifa.pc_write_o, ifa.ifid_flush_o, ifa.idex_bubble_o} !== 4'b1000) begin
                bad++;
                $display("FAIL comb_stall c=%0d got=%b exp=1000", c,
                         {ifa.mem_stall_o, ifa.pc_write_o, ifa.ifid_flush_o, ifa.idex_bubble_o});
            end
            next_cycle();
        end
        ack = 1'b0;
        @(negedge clk_i);
        total++;
        if (ifa.stall_cnt_o !== 32'd0) begin bad++; $display("FAIL comb_cnt_hold got=%0d exp=0", ifa.stall_cnt_o); end
        total++;
        if ({ifa.mem_stall_o, ifa.idex_bubble_o, ifa.ifid_flush_o, ifa.pc_write_o} !== 4'b0100) begin
            bad++;
            $display("FAIL comb_bubble got=%b exp=0100",
                     {ifa.mem_stall_o, ifa.idex_bubble_o, ifa.ifid_flush_o, ifa.pc_write_o});
        end
        next_cycle();
        memread = 1'b0;
        @(negedge clk_i);
        total++;
        if ({ifa.ifid_flush_o, ifa.pc_write_o, ifa.idex_bubble_o} !== 3'b110) begin
            bad++;
            $display("FAIL comb_flush got=%b exp=110", {ifa.ifid_flush_o, ifa.pc_write_o, ifa.idex_bubble_o});
        end
        total++;
        if (ifa.stall_cnt_o !== 32'd1) begin bad++; $display("FAIL comb_cnt got=%0d exp=1", ifa.stall_cnt_o); end
        clear_inputs();
    endtask

    task automatic test_timeout();
        do_reset();
        req = 1'b1; hit = 1'b0;
        next_cycle();
        // Now in WAIT cycle 1; err registers at the edge ending WAIT cycle 8.
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk_i);
            if (k == 1 || k == 8) begin
                total++;
                if (ifb.err_timeout_o !== 1'b0) begin bad++; $display("FAIL wd_early k=%0d got=%b exp=0", k, ifb.err_timeout_o); end
            end
            next_cycle();
        end
        @(negedge clk_i);
        total++;
        if (ifb.err_timeout_o !== 1'b1) begin bad++; $display("FAIL wd_set got=%b exp=1", ifb.err_timeout_o); end
        for (int k = 0; k < 4; k++) next_cycle();
        @(negedge clk_i);
        total++;
        if (ifb.err_timeout_o !== 1'b1 || ifb.mem_stall_o !== 1'b1) begin
            bad++;
            $display("FAIL wd_sticky got err=%b stall=%b exp=1/1", ifb.err_timeout_o, ifb.mem_stall_o);
        end
        next_cycle();
        rst_i = 1'b1;
        @(negedge clk_i);
        total++;
        if (ifb.mem_stall_o !== 1'b0) begin bad++; $display("FAIL wd_rst_stall got=%b exp=0", ifb.mem_stall_o); end
        next_cycle();
        rst_i = 1'b0;
        req = 1'b0;
        @(negedge clk_i);
        total++;
        if (ifb.err_timeout_o !== 1'b0 || ifb.mem_stall_o !== 1'b0) begin
            bad++;
            $display("FAIL wd_abandon got err=%b stall=%b exp=0/0", ifb.err_timeout_o, ifb.mem_stall_o);
        end
        clear_inputs();
    endtask

    task automatic test_saturate();
        logic [1:0] exp_b [5];
        exp_b[0] = 2'd1; exp_b[1] = 2'd2; exp_b[2] = 2'd3; exp_b[3] = 2'd3; exp_b[4] = 2'd3;
        do_reset();
        memread = 1'b1; rd = 5'd12; rs1 = 5'd12;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            @(negedge clk_i);
            total++;
            if (ifb.stall_cnt_o !== exp_b[i]) begin
                bad++;
                $display("FAIL sat_cnt i=%0d got=%0d exp=%0d", i, ifb.stall_cnt_o, exp_b[i]);
            end
        end
        total++;
        if (ifa.stall_cnt_o !== 32'd5) begin bad++; $display("FAIL wide_cnt got=%0d exp=5", ifa.stall_cnt_o); end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_load_use();
        test_x0_branch();
        test_miss();
        test_combined();
        test_timeout();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
